// File: rtl/freq_meter_if.sv
// Measurement interface for freq_meter: run control and measured signal in, windowed count out.
// slave = the meter itself, master = the consumer driving enable/sig_in.
interface freq_meter_if #(
  parameter int unsigned COUNT_W = 16
) ();
  logic               enable;
  logic               sig_in;
  logic [COUNT_W-1:0] count_out;
  logic               count_valid;
  logic               overflow;
  logic               busy;

  modport master (
    output enable,
    output sig_in,
    input  count_out,
    input  count_valid,
    input  overflow,
    input  busy
  );

  modport slave (
    input  enable,
    input  sig_in,
    output count_out,
    output count_valid,
    output overflow,
    output busy
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over CLK_HZ/GATE_RATE cycles.
// Define FREQ_METER_AVG_EN to publish the running mean of the last four windows.
module freq_meter #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned GATE_RATE   = 100,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  freq_meter_if.slave     bus
);

  localparam int unsigned WINDOW = CLK_HZ / GATE_RATE;
  localparam int unsigned GATE_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [GATE_W-1:0]  GateLast = GATE_W'(WINDOW - 1);
  localparam logic [COUNT_W-1:0] CntMax   = '1;
  localparam logic [2:0]         ArmLast  = 3'(SYNC_STAGES);

  typedef enum logic [1:0] {StIdle, StArm, StGate, StDone} state_e;

  state_e               state_q;
  logic [2:0]           arm_q;
  logic [GATE_W-1:0]    gate_q;
  logic [COUNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic                 sat_q, sat_d;
  logic [COUNT_W-1:0]   count_out_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 busy_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sig_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    if (sig_rise) begin
      if (edge_cnt_q == CntMax) begin
        sat_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + COUNT_W'(1);
      end
    end
  end

  logic done_fire;
  logic go_idle;

  // done_fire: final gate cycle; its edge is already folded into edge_cnt_d.
  assign done_fire = (state_q == StGate) && bus.enable && (gate_q == GateLast);
  assign go_idle   = (state_q != StIdle) && !bus.enable;

  logic [COUNT_W-1:0] pub_cnt;
  logic               pub_ovf;
  logic               pub_ok;

`ifdef FREQ_METER_AVG_EN
  logic [3:0][COUNT_W-1:0] hcnt_q;
  logic [3:0]              hsat_q;
  logic [COUNT_W+1:0]      sum_q, sum_d;
  logic [1:0]              fill_q;

  // Unfilled history slots hold zero, so the oldest entry can always be subtracted.
  assign sum_d   = sum_q - {2'b00, hcnt_q[3]} + {2'b00, edge_cnt_d};
  assign pub_cnt = sum_d[COUNT_W+1:2];
  assign pub_ovf = |{hsat_q[2:0], sat_d};
  assign pub_ok  = (fill_q == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      hsat_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (go_idle) begin
      hcnt_q <= '0;
      hsat_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else if (done_fire) begin
      hcnt_q <= {hcnt_q[2:0], edge_cnt_d};
      hsat_q <= {hsat_q[2:0], sat_d};
      sum_q  <= sum_d;
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
    end
  end
`else
  assign pub_cnt = edge_cnt_d;
  assign pub_ovf = sat_d;
  assign pub_ok  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      arm_q       <= '0;
      gate_q      <= '0;
      edge_cnt_q  <= '0;
      sat_q       <= 1'b0;
      count_out_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (go_idle) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.enable) begin
              state_q <= StArm;
              arm_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          StArm: begin
            // Hold off counting until the synchronizer has been flushed.
            if (arm_q == ArmLast) begin
              state_q    <= StGate;
              gate_q     <= '0;
              edge_cnt_q <= '0;
              sat_q      <= 1'b0;
            end else begin
              arm_q <= arm_q + 3'd1;
            end
          end
          StGate: begin
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            gate_q     <= gate_q + GATE_W'(1);
            if (done_fire) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              valid_q <= pub_ok;
              if (pub_ok) begin
                count_out_q <= pub_cnt;
                ovf_q       <= pub_ovf;
              end
            end
          end
          StDone: begin
            // Edges seen in this cycle are dropped by the counter clear.
            state_q    <= StGate;
            busy_q     <= 1'b1;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.count_out   = count_out_q;
  assign bus.count_valid = valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a cycle-indexed sig_in plan is drawn per window, a window
// model counts plan rises landing in each gate and queues the expected publications.
module tb_freq_meter;

  localparam int unsigned CLK_HZ    = 1000;
  localparam int unsigned GATE_RATE = 10;
  localparam int unsigned COUNT_W   = 4;
  localparam int unsigned SYNC      = 2;
  localparam int          W         = CLK_HZ / GATE_RATE;
  localparam int          MAXC      = (1 << COUNT_W) - 1;
  localparam int          PLAN_N    = 16384;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  freq_meter_if #(.COUNT_W(COUNT_W)) bus ();

  freq_meter #(
    .CLK_HZ     (CLK_HZ),
    .GATE_RATE  (GATE_RATE),
    .COUNT_W    (COUNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit plan [PLAN_N];

  typedef struct {
    int cnt;
    bit ovf;
    int at;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_out = 0;
  bit   last_ovf = 1'b0;
  int   hist_c[$];
  bit   hist_s[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // sig_in follows the plan: plan[t] is driven just after clock edge t.
  initial begin
    bus.sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.sig_in = (cyc < PLAN_N) ? plan[cyc] : 1'b0;
    end
  end

  // Monitor: every count_valid pops one expectation.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.count_valid) begin
        check("valid_not_back_to_back", int'(prev), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("count_out", int'(bus.count_out), e.cnt);
          check("overflow", int'(bus.overflow), int'(e.ovf));
          check("valid_cycle", cyc, e.at);
        end
      end
      prev = bus.count_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // A rise driven after edge t is counted at edge t+SYNC+1.
  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int t = lo - SYNC - 1; t <= hi - SYNC - 1; t++) begin
      if (t >= 1 && t < PLAN_N && plan[t] && !plan[t-1]) n++;
    end
    return n;
  endfunction

  task automatic publish(input int edges, input int at);
    int c;
    bit s;
    s = (edges > MAXC);
    c = s ? MAXC : edges;
`ifdef FREQ_METER_AVG_EN
    hist_c.push_back(c);
    hist_s.push_back(s);
    if (hist_c.size() > 4) begin
      void'(hist_c.pop_front());
      void'(hist_s.pop_front());
    end
    if (hist_c.size() == 4) begin
      int sum = 0;
      bit any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        sum += hist_c[i];
        any |= hist_s[i];
      end
      exp_q.push_back('{sum / 4, any, at});
      last_out = sum / 4;
      last_ovf = any;
    end
`else
    exp_q.push_back('{c, s, at});
    last_out = c;
    last_ovf = s;
`endif
  endtask

  // pers[k]: >0 fixed square period, 0 random period/phase,
  // -1 single rise counted on the last gate cycle, -2 single rise landing in DONE.
  task automatic run(input int pers[$]);
    int p0, g, lo, sa, per, ph, n, target;
    n  = pers.size();
    p0 = cyc;
    g  = p0 + 5;
    hist_c.delete();
    hist_s.delete();
    for (int k = 0; k < n; k++) begin
      lo  = g + k * (W + 1);
      sa  = lo - SYNC - 1;
      per = pers[k];
      ph  = 0;
      if (per == 0) begin
        per = $urandom_range(4, 30);
        ph  = $urandom_range(0, per - 1);
      end
      for (int t = sa; t <= sa + W; t++) begin
        plan[t] = (per > 0 && t < sa + W) ? (((t - sa + ph) % per) < per / 2) : 1'b0;
      end
      if (per == -1) for (int t = lo + W - 4; t <= lo + W - 2; t++) plan[t] = 1'b1;
      if (per == -2) for (int t = lo + W - 3; t <= lo + W - 1; t++) plan[t] = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      lo = g + k * (W + 1);
      publish(rises(lo, lo + W - 1), lo + W - 1);
    end
    bus.enable = 1'b1;
    tick(1);
    check("busy_in_arm", int'(bus.busy), 1);
    tick(9);
    check("busy_in_gate", int'(bus.busy), 1);
    target = g + (n - 1) * (W + 1) + W - 1;
    tick(target - cyc);
    bus.enable = 1'b0;
    tick(2);
    check("busy_after_run", int'(bus.busy), 0);
    tick(5);
  endtask

  initial begin
    int p0, g, guard;
    bus.enable = 1'b0;

    tick(3);
    check("rst_count_out", int'(bus.count_out), 0);
    check("rst_count_valid", int'(bus.count_valid), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    tick(4);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_count_out", int'(bus.count_out), 0);

    run('{10, 10, 10, 10, 10});
    run('{4, 20, 4, 20, 10});
    run('{0, 0, 0, 0, 0, 0});
    run('{-1, -2, -1, -2});
    run('{10, 10, 10, 4});

    // Abort on gate cycle 50: nothing published, outputs hold.
    p0 = cyc;
    g  = p0 + 5;
    for (int t = p0 + 2; t <= g + 60; t++) plan[t] = ((t - p0 - 2) % 10) < 5;
    bus.enable = 1'b1;
    tick(g + 49 - cyc);
    bus.enable = 1'b0;
    tick(2);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_hold_count", int'(bus.count_out), last_out);
    check("abort_hold_ovf", int'(bus.overflow), int'(last_ovf));
    tick(5);
    run('{10, 10, 10, 10});

    // Asynchronous reset mid-gate.
    p0 = cyc;
    g  = p0 + 5;
    for (int t = p0 + 2; t <= g + 25; t++) plan[t] = ((t - p0 - 2) % 10) < 5;
    for (int t = g + 26; t <= g + 60; t++) plan[t] = 1'b0;
    bus.enable = 1'b1;
    tick(g + 30 - cyc);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_count_out", int'(bus.count_out), 0);
    check("async_rst_valid", int'(bus.count_valid), 0);
    check("async_rst_overflow", int'(bus.overflow), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    tick(3);
    check("in_rst_busy", int'(bus.busy), 0);
    bus.enable = 1'b0;
    tick(1);
    rst_n    = 1'b1;
    last_out = 0;
    last_ovf = 1'b0;
    tick(5);
    check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_count_out", int'(bus.count_out), 0);
    run('{10, 20, 10, 20});

    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      tick(1);
      guard++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
